// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds, overflow/underflow
// pulses and synchronous flush. Fullness is tracked by count, never by
// pointer equality, so DEPTH does not have to be a power of two.
// Optional feature: define SYNC_FIFO_FLEX_PARITY_EN to store an even-parity
// bit per entry and report mismatches on parity_err.
module sync_fifo_flex #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic                         rd_en,
    input  logic                         flush,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
`ifdef SYNC_FIFO_FLEX_PARITY_EN
    output logic                         underflow,
    output logic                         parity_err
`else
    output logic                         underflow
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
`ifdef SYNC_FIFO_FLEX_PARITY_EN
    localparam int MW = DATA_WIDTH + 1;
`else
    localparam int MW = DATA_WIDTH;
`endif

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [MW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr_acc;
    logic          rd_acc;
    logic [CW-1:0] count_next;
    logic [MW-1:0] wr_word;
    logic [MW-1:0] rd_word;

    // Request acceptance, next occupancy and the words moving in/out of storage.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_acc     = wr_en & (~full | rd_en);
        rd_acc     = rd_en & ~empty;
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_next = count - 1'b1;
        end
`ifdef SYNC_FIFO_FLEX_PARITY_EN
        wr_word = {^data_in, data_in};
`else
        wr_word = data_in;
`endif
        rd_word = mem[rd_ptr];
    end

    // Storage array: written only by accepted writes outside reset and flush.
    // NOTE: storage is deliberately not reset; the count guarantees stale words are never read.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && wr_acc) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    // Pointers, count, registered flags, error pulses and read data.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            data_out     <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
`ifdef SYNC_FIFO_FLEX_PARITY_EN
            parity_err   <= 1'b0;
`endif
        end else if (flush) begin
            // Flush beats any same-cycle request; data_out keeps its last value.
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
`ifdef SYNC_FIFO_FLEX_PARITY_EN
            parity_err   <= 1'b0;
`endif
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr   <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
                data_out <= rd_word[DATA_WIDTH-1:0];
            end
            count        <= count_next;
            full         <= (count_next == DEPTH_C);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_C);
            almost_empty <= (count_next <= AE_C);
            overflow     <= wr_en & ~wr_acc;
            underflow    <= rd_en & empty;
`ifdef SYNC_FIFO_FLEX_PARITY_EN
            parity_err   <= rd_acc & ((^rd_word[DATA_WIDTH-1:0]) != rd_word[DATA_WIDTH]);
`endif
        end
    end

endmodule
